imem_port_arbiter: RTL
======================

# imem_port_arbiter

Sequencing and arbitration controller for the single-ported, byte-addressed instruction memory. It owns the memory port. After reset it runs a boot-load phase in which a byte-serial program loader fills memory while the fetch stage is stalled. It then hands the port to the IF stage. In run mode, loader writes are still served in fetch-idle cycles, with a starvation guard. The block sits between the IF stage, the program loader and the instruction memory array.

## Interface
Parameters:
- ADDR_W, 10, byte-address width of the memory (1024 bytes)
- STARVE_LIM, 4, consecutive cycles a loader request may wait in RUN before it is forced through
- NOP_INSTR, 32'h0000_0013, word returned for illegal fetches

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request from IF stage
- if_addr  in  32  fetch byte address
- if_ready  out  1  fetch accepted this cycle when if_req & if_ready
- if_valid  out  1  if_instr valid this cycle (one cycle after accept)
- if_instr  out  32  fetched instruction, little-endian
- if_err  out  1  with if_valid: fetch was misaligned or out of range
- ld_valid  in  1  loader byte available
- ld_addr  in  ADDR_W  loader byte address
- ld_byte  in  8  loader data
- ld_ready  out  1  loader byte accepted when ld_valid & ld_ready
- ld_done  in  1  one-cycle pulse: program load complete
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write (byte) when 1, read (word) when 0
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  32  bytes addr..addr+3, little-endian, valid the cycle after a read
- stall  out  1  high while in LOAD; IF stage must hold PC
- ld_count  out  16  bytes written since reset, saturating at 16'hFFFF

## Operation
- States: LOAD (reset state), RUN.
- LOAD:
  - if_ready=0, stall=1.
  - ld_ready=1; each accepted byte is written: mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_byte.
  - ld_done moves the FSM to RUN at the next edge. A byte accepted in the same cycle as ld_done is still written.
- RUN:
  - stall=0.
  - Default priority is fetch: if_ready=1, and ld_ready=!if_req.
  - Starvation counter: increments each cycle ld_valid=1 and the loader byte is not accepted. It clears when a loader byte is accepted or when ld_valid=0.
  - When the counter equals STARVE_LIM: ld_ready=1 and if_ready=0 for that cycle. The loader byte is written and the counter clears.
- Fetch legality check in the accept cycle:
  - Illegal if if_addr[1:0]!=0 or if_addr > 2^ADDR_W-4.
  - An illegal fetch is accepted with mem_en=0. The next cycle gives if_valid=1, if_instr=NOP_INSTR, if_err=1.
  - A legal fetch drives mem_en=1, mem_we=0, mem_addr=if_addr[ADDR_W-1:0]. The next cycle gives if_valid=1, if_instr=mem_rdata, if_err=0.
- Idle cycle (no grant): mem_en=0, mem_we=0; mem_addr and mem_wdata hold their previous values.
- ld_count increments on every accepted loader byte, in both states, and saturates.
- ld_done in RUN is ignored.

## Timing
- Reset (asynchronous, any cycle):
  - State goes to LOAD. stall=1.
  - if_valid=0, if_err=0, if_instr=0, if_ready=0, ld_ready=1.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - ld_count=0, starvation counter=0.
  - An in-flight fetch is dropped; no if_valid follows.
- Outputs by type:
  - Grant outputs (if_ready, ld_ready, mem_en, mem_we, mem_addr, mem_wdata) are combinational from state, request inputs and counter.
  - if_valid, if_err and the NOP select are registered.
- Fetch latency: exactly 1 cycle from accept to if_valid. Back-to-back fetches sustain 1 instruction/cycle.
- At most one memory access per cycle; a loader write and a fetch never share a cycle.
- LOAD→RUN: the first fetch can be accepted in the cycle after the ld_done pulse.
- A fetch to a word written in the immediately preceding cycle returns the new data (the memory writes at the edge and reads after it).

## Test plan
- Boot load:
  - Stimulus: after reset, write bytes 13,00,10,00 to addresses 4..7, pulse ld_done, then fetch 0x4.
  - Required: stall=1 until ld_done; if_valid one cycle after accept with if_instr=0x00100013, if_err=0; ld_count=4.
- Back-to-back fetch:
  - Stimulus: in RUN, if_req held high with addresses 0x4, 0x8, 0xC.
  - Required: three consecutive if_valid cycles returning the stored words.
- Starvation guard:
  - Stimulus: in RUN, if_req and ld_valid both held high continuously.
  - Required: the loader byte is written in the 5th cycle (after STARVE_LIM=4 denied cycles), with if_ready=0 that cycle only; fetches resume the following cycle.
- Illegal fetch:
  - Stimulus: fetch 0x6, then fetch 0x3FE.
  - Required: both return if_instr=0x00000013, if_err=1, mem_en=0 in the accept cycle.
- Simultaneous ld_done and byte:
  - Stimulus: ld_valid with byte 0xAA at address 0x10 in the same cycle as ld_done.
  - Required: 0xAA written; state RUN at the next edge; a later fetch of 0x10 returns low byte 0xAA.
- Reset mid-fetch:
  - Stimulus: assert rst_n=0 asynchronously between a fetch accept and the next edge.
  - Required: immediately if_valid=0, stall=1, ld_count=0; no if_valid after release.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
//   Owns the single instruction-memory port. After reset it stays in LOAD,
//   where the byte-serial program loader fills memory while IF is stalled.
//   After ld_done it moves to RUN, where fetches have priority and loader
//   writes use fetch-idle cycles. A starvation counter forces a waiting
//   loader byte through after STARVE_LIM denied cycles.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   if_req/if_addr      fetch request and byte address from IF
//   if_ready            fetch accepted when if_req & if_ready
//   if_valid/if_instr   fetched word, one cycle after accept
//   if_err              with if_valid: fetch was misaligned or out of range
//   ld_valid/ld_addr/ld_byte/ld_ready   loader byte handshake
//   ld_done             one-cycle pulse ending the boot load
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory port
//   stall               high while in LOAD
//   ld_count            accepted loader bytes since reset, saturating
module imem_port_arbiter #(
    parameter int          ADDR_W     = 10,
    parameter int          STARVE_LIM = 4,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ready,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic              if_err,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_byte,
    output logic              ld_ready,
    input  logic              ld_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              stall,
    output logic [15:0]       ld_count
);

    localparam int          CNT_W     = $clog2(STARVE_LIM + 1);
    localparam logic [31:0] MAX_FETCH = (32'd1 << ADDR_W) - 32'd4;

    typedef enum logic {LOAD, RUN} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic              valid_q, err_q;
    logic [15:0]       cnt_q;

    logic force_ld, fetch_legal, fetch_acc, ld_acc;

    always_comb begin
        force_ld    = (state_q == RUN) && (starve_q == CNT_W'(STARVE_LIM));
        fetch_legal = (if_addr[1:0] == 2'b00) && (if_addr <= MAX_FETCH);

        // LOAD: loader only. RUN: fetch first unless the loader has starved.
        if_ready = 1'b0;
        ld_ready = 1'b1;
        if (state_q == RUN && !force_ld) begin
            if_ready = 1'b1;
            ld_ready = !if_req;
        end

        fetch_acc = if_req & if_ready;
        ld_acc    = ld_valid & ld_ready;

        // Idle cycles replay the last driven address/data.
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (ld_acc) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_byte;
        end else if (fetch_acc && fetch_legal) begin
            mem_en   = 1'b1;
            mem_addr = if_addr[ADDR_W-1:0];
        end

        starve_d = (ld_valid && !ld_acc) ? starve_q + 1'b1 : '0;

        state_d = state_q;
        if (state_q == LOAD && ld_done) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            starve_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= mem_addr;
            wdata_q  <= mem_wdata;
            valid_q  <= fetch_acc;
            err_q    <= fetch_acc & !fetch_legal;
            if (ld_acc && cnt_q != '1) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign if_valid = valid_q;
    assign if_err   = err_q;
    assign if_instr = !valid_q ? '0 : (err_q ? NOP_INSTR : mem_rdata);
    assign stall    = (state_q == LOAD);
    assign ld_count = cnt_q;

endmodule
